fp_normalize_round: RTL and testbench

Post-add stage of the floating-point adder: consumes the raw significand sum and carry from the integer adder (plus the sign/exponent carried alongside), normalizes it by iterative shifting, rounds to nearest-even, and emits a packed result. Multi-cycle FSM with valid/ready handshakes on both sides; sits directly downstream of the integer adder.

---
 rtl/fp_pkg.sv | 29 ++
 rtl/fp_round_rne.sv | 78 +++++++
 rtl/fp_normalize_round.sv | 163 ++++++++++++++++
 tb/tb_fp_normalize_round.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared constants and types for the floating-point adder post-add stage.
//   SUM_W   : integer adder width; layout {hidden, mantissa, extension bits}
//   EXP_W   : biased exponent width
//   MAN_W   : stored mantissa width
//   BIAS    : exponent bias
//   EXP_MAX : reserved all-ones exponent (infinity / overflow)
//   state_t : normalize/round controller states
// -----------------------------------------------------------------------------
package fp_pkg;

   localparam int SUM_W   = 32;
   localparam int EXP_W   = 8;
   localparam int MAN_W   = 23;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = 255;

   // guard bit sits directly below the mantissa LSB
   localparam int G_POS   = SUM_W - 2 - MAN_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_NORM  = 2'd1,
      ST_ROUND = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

endpackage

// File: rtl/fp_round_rne.sv
// -----------------------------------------------------------------------------
// fp_round_rne
// Combinational round-to-nearest-even and result packing for a normalized
// working word.
//   w           in  SUM_W   normalized word {hidden, mantissa, guard, round, sticky...}
//   e           in  EXP_W+1 working exponent (may exceed the field range)
//   sign        in  1       operand sign
//   r_sign      out 1       packed result sign
//   r_exp       out EXP_W   packed result exponent field
//   r_man       out MAN_W   packed result mantissa field
//   r_zero      out 1       exact zero result
//   r_overflow  out 1       result saturated to EXP_MAX
//   r_inexact   out 1       any discarded bit was set
// -----------------------------------------------------------------------------
module fp_round_rne
   import fp_pkg::*;
(
   input  logic [SUM_W-1:0] w,
   input  logic [EXP_W:0]   e,
   input  logic             sign,
   output logic             r_sign,
   output logic [EXP_W-1:0] r_exp,
   output logic [MAN_W-1:0] r_man,
   output logic             r_zero,
   output logic             r_overflow,
   output logic             r_inexact
);

   localparam logic [EXP_W:0] EXP_LIMIT = (EXP_W+1)'(EXP_MAX);

   logic             hidden;
   logic [MAN_W-1:0] man;
   logic             g_bit;
   logic             r_bit;
   logic             s_bit;
   logic             l_bit;
   logic             up;
   logic [MAN_W+1:0] sig;
   logic [EXP_W:0]   e_rnd;
   logic             w_zero;

   assign hidden = w[SUM_W-1];
   assign man    = w[SUM_W-2 -: MAN_W];
   assign g_bit  = w[G_POS];
   assign r_bit  = w[G_POS-1];
   assign s_bit  = |w[G_POS-2:0];
   assign l_bit  = w[G_POS+1];
   assign w_zero = (w == '0);

   // ties round up only when the kept LSB is odd
   assign up  = g_bit & (r_bit | s_bit | l_bit);
   assign sig = {1'b0, hidden, man} + {{(MAN_W+1){1'b0}}, up};

   // an all-ones significand rolling over bumps the exponent; the stored
   // mantissa bits are already zero in that case
   assign e_rnd = e + {{EXP_W{1'b0}}, sig[MAN_W+1]};

   always_comb begin
      r_sign     = sign;
      r_exp      = '0;
      r_man      = '0;
      r_zero     = 1'b0;
      r_overflow = 1'b0;
      r_inexact  = g_bit | r_bit | s_bit;
      if (w_zero) begin
         r_sign = 1'b0;
         r_zero = 1'b1;
      end else if (e_rnd >= EXP_LIMIT) begin
         r_exp      = EXP_LIMIT[EXP_W-1:0];
         r_overflow = 1'b1;
      end else begin
         r_man = sig[MAN_W-1:0];
         // no hidden bit after rounding means the value is subnormal
         r_exp = (sig[MAN_W+1] | sig[MAN_W]) ? e_rnd[EXP_W-1:0] : '0;
      end
   end

endmodule

// File: rtl/fp_normalize_round.sv
// -----------------------------------------------------------------------------
// fp_normalize_round
// Post-add stage of the floating-point adder. Takes the raw significand sum
// and carry from the integer adder, normalizes it one bit per cycle, rounds to
// nearest-even and presents a packed result with status flags.
//
//   clk           in  1      clock
//   rst           in  1      synchronous active-high reset
//   in_valid      in  1      input word valid
//   in_ready      out 1      block can accept (IDLE only, low while rst)
//   in_sum        in  SUM_W  adder sum
//   in_carry      in  1      adder carry, honoured only for add
//   in_op         in  1      1 = add, 0 = subtract
//   in_sign       in  1      result sign
//   in_exp        in  EXP_W  larger operand's biased exponent
//   out_valid     out 1      result valid
//   out_ready     in  1      consumer accepts
//   out_sign/out_exp/out_man  out  packed result
//   out_zero/out_overflow/out_inexact  out  status flags
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for an input word, in_ready high
// ST_NORM  | one normalize step per cycle (right by one or left by one)
// ST_ROUND | rounder output captured into the result registers
// ST_OUT   | result held with out_valid high until out_ready
// -----------------------------------------------------------------------------
module fp_normalize_round
   import fp_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SUM_W-1:0] in_sum,
   input  logic             in_carry,
   input  logic             in_op,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [EXP_W-1:0] out_exp,
   output logic [MAN_W-1:0] out_man,
   output logic             out_zero,
   output logic             out_overflow,
   output logic             out_inexact
);

   localparam logic [EXP_W:0] E_ONE = (EXP_W+1)'(1);

   state_t           state;
   state_t           state_nxt;

   logic [SUM_W:0]   w;
   logic [EXP_W:0]   e;
   logic             sign;

   logic             w_top;
   logic             w_hidden;
   logic             w_zero;
   logic             e_min;
   logic             norm_done;

   logic             rnd_sign;
   logic [EXP_W-1:0] rnd_exp;
   logic [MAN_W-1:0] rnd_man;
   logic             rnd_zero;
   logic             rnd_overflow;
   logic             rnd_inexact;

   assign w_top    = w[SUM_W];
   assign w_hidden = w[SUM_W-1];
   assign w_zero   = (w == '0);
   assign e_min    = (e == E_ONE);

   // anything other than a carry-out or a pending left shift ends normalization;
   // stopping at E==1 leaves the value subnormal instead of underflowing
   assign norm_done = w_zero | w_hidden | e_min;

   assign in_ready  = (state == ST_IDLE) & ~rst;
   assign out_valid = (state == ST_OUT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (in_valid) state_nxt = ST_NORM;
         ST_NORM:  if (w_top || norm_done) state_nxt = ST_ROUND;
         ST_ROUND: state_nxt = ST_OUT;
         ST_OUT:   if (out_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w    <= '0;
         e    <= '0;
         sign <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  // a borrow on subtract carries no magnitude
                  w    <= {in_carry & in_op, in_sum};
                  e    <= {1'b0, in_exp};
                  sign <= in_sign;
               end
            end
            ST_NORM: begin
               if (w_top) begin
                  // the bit shifted out is folded into the sticky position
                  w <= {1'b0, w[SUM_W:2], w[1] | w[0]};
                  e <= e + E_ONE;
               end else if (!norm_done) begin
                  w <= {w[SUM_W-1:0], 1'b0};
                  e <= e - E_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   fp_round_rne u_round (
      .w          (w[SUM_W-1:0]),
      .e          (e),
      .sign       (sign),
      .r_sign     (rnd_sign),
      .r_exp      (rnd_exp),
      .r_man      (rnd_man),
      .r_zero     (rnd_zero),
      .r_overflow (rnd_overflow),
      .r_inexact  (rnd_inexact)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_sign     <= 1'b0;
         out_exp      <= '0;
         out_man      <= '0;
         out_zero     <= 1'b0;
         out_overflow <= 1'b0;
         out_inexact  <= 1'b0;
      end else if (state == ST_ROUND) begin
         out_sign     <= rnd_sign;
         out_exp      <= rnd_exp;
         out_man      <= rnd_man;
         out_zero     <= rnd_zero;
         out_overflow <= rnd_overflow;
         out_inexact  <= rnd_inexact;
      end
   end

endmodule

// File: tb/tb_fp_normalize_round.sv
// -----------------------------------------------------------------------------
// tb_fp_normalize_round
// Directed and randomized stimulus for fp_normalize_round, checked against an
// arithmetic reference model of normalize + round-to-nearest-even.
// -----------------------------------------------------------------------------
module tb_fp_normalize_round;

   typedef struct packed {
      logic        sgn;
      logic [7:0]  ex;
      logic [22:0] man;
      logic        zero;
      logic        ovf;
      logic        inx;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_sum;
   logic        in_carry;
   logic        in_op;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic        out_valid;
   logic        out_ready;
   logic        out_sign;
   logic [7:0]  out_exp;
   logic [22:0] out_man;
   logic        out_zero;
   logic        out_overflow;
   logic        out_inexact;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   fp_normalize_round dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sum       (in_sum),
      .in_carry     (in_carry),
      .in_op        (in_op),
      .in_sign      (in_sign),
      .in_exp       (in_exp),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sign     (out_sign),
      .out_exp      (out_exp),
      .out_man      (out_man),
      .out_zero     (out_zero),
      .out_overflow (out_overflow),
      .out_inexact  (out_inexact)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, want);
   endtask

   // Value = {carry, sum} read as a fixed-point number with 1.0 at bit 31,
   // scaled by 2^(exp-bias). Normalize, then keep 24 significant bits and
   // round the 8-bit remainder against one half.
   function automatic res_t ref_model(input logic [31:0] sum, input logic carry,
                                      input logic op, input logic sgn,
                                      input int ex, output int lat);
      res_t   r;
      longint v;
      longint m24;
      longint rem;
      int     e;
      bit     up;
      r   = '0;
      v   = longint'({carry & op, sum});
      e   = ex;
      lat = 2;
      if (v == 0) begin
         r.zero = 1'b1;
         return r;
      end
      if (v >= (longint'(1) << 32)) begin
         v = (v >> 1) | (v & 1);
         e = e + 1;
      end else begin
         while (v < (longint'(1) << 31) && e > 1) begin
            v   = v * 2;
            e   = e - 1;
            lat = lat + 1;
         end
      end
      m24   = v / 256;
      rem   = v % 256;
      r.inx = (rem != 0);
      up    = (rem > 128) || (rem == 128 && (m24 % 2) == 1);
      if (up) m24 = m24 + 1;
      if (m24 == (longint'(1) << 24)) begin
         m24 = longint'(1) << 23;
         e   = e + 1;
      end
      r.sgn = sgn;
      if (e >= 255) begin
         r.ex  = 8'd255;
         r.ovf = 1'b1;
      end else begin
         r.man = 23'(m24 % (longint'(1) << 23));
         r.ex  = (m24 >= (longint'(1) << 23)) ? 8'(e) : 8'd0;
      end
      return r;
   endfunction

   task automatic do_op(input logic [31:0] sum, input logic carry, input logic op,
                        input logic sgn, input logic [7:0] ex, input int stall);
      res_t want;
      int   want_lat;
      int   lat;
      want = ref_model(sum, carry, op, sgn, int'(ex), want_lat);
      @(negedge clk);
      check_val("in_ready_idle", in_ready, 1);
      in_sum    = sum;
      in_carry  = carry;
      in_op     = op;
      in_sign   = sgn;
      in_exp    = ex;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      check_val("in_ready_busy", in_ready, 0);
      // keep in_valid up with different data; the busy block must ignore it
      in_sum   = $urandom;
      in_exp   = 8'($urandom_range(1, 254));
      in_carry = 1'b1;
      in_op    = 1'b1;
      in_sign  = ~sgn;
      lat = 0;
      while (!out_valid && lat < 80) begin
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      check_val("latency", lat, want_lat);
      check_val("out_valid", out_valid, 1);
      check_val("out_sign", out_sign, want.sgn);
      check_val("out_exp", out_exp, want.ex);
      check_val("out_man", out_man, want.man);
      check_val("out_zero", out_zero, want.zero);
      check_val("out_overflow", out_overflow, want.ovf);
      check_val("out_inexact", out_inexact, want.inx);
      repeat (stall) begin
         @(negedge clk);
         check_val("hold_result",
                   {out_sign, out_exp, out_man, out_zero, out_overflow, out_inexact}, want);
         check_val("hold_valid", out_valid, 1);
         check_val("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_val("out_valid_drop", out_valid, 0);
   endtask

   initial begin
      logic [31:0] sum;
      logic [7:0]  ex;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sum    = '0;
      in_carry  = 1'b0;
      in_op     = 1'b0;
      in_sign   = 1'b0;
      in_exp    = '0;
      out_ready = 1'b0;

      repeat (3) @(negedge clk);
      check_val("rst_in_ready", in_ready, 0);
      check_val("rst_out_valid", out_valid, 0);
      rst = 1'b0;
      @(negedge clk);
      check_val("post_rst_in_ready", in_ready, 1);
      check_val("post_rst_outputs",
                {out_valid, out_sign, out_exp, out_man, out_zero, out_overflow, out_inexact}, 0);

      do_op(32'h8000_0000, 1'b0, 1'b1, 1'b0, 8'd127, 0);
      do_op(32'h0000_0000, 1'b1, 1'b1, 1'b0, 8'd127, 0);
      do_op(32'h0000_8000, 1'b0, 1'b0, 1'b1, 8'd127, 0);
      do_op(32'h0000_0000, 1'b0, 1'b0, 1'b1, 8'd127, 0);
      do_op(32'h8000_0180, 1'b0, 1'b1, 1'b0, 8'd127, 0);
      do_op(32'h8000_0080, 1'b0, 1'b1, 1'b0, 8'd127, 0);
      do_op(32'h8000_0040, 1'b0, 1'b1, 1'b0, 8'd127, 0);
      do_op(32'hFFFF_FF80, 1'b0, 1'b1, 1'b1, 8'd254, 0);
      do_op(32'h4000_0000, 1'b0, 1'b0, 1'b0, 8'd1, 0);
      do_op(32'h8000_0000, 1'b1, 1'b0, 1'b0, 8'd100, 0);
      do_op(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 8'd254, 0);
      do_op(32'h0000_0001, 1'b0, 1'b0, 1'b0, 8'd200, 0);
      do_op(32'h8000_0180, 1'b0, 1'b1, 1'b1, 8'd127, 5);

      // abort a long normalization with reset
      @(negedge clk);
      in_sum   = 32'h0000_0001;
      in_carry = 1'b0;
      in_op    = 1'b0;
      in_exp   = 8'd100;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_val("abort_out_valid", out_valid, 0);
      check_val("abort_in_ready_rst", in_ready, 0);
      check_val("abort_outputs_clear",
                {out_sign, out_exp, out_man, out_zero, out_overflow, out_inexact}, 0);
      rst = 1'b0;
      @(negedge clk);
      check_val("abort_in_ready_after", in_ready, 1);
      check_val("abort_out_valid_after", out_valid, 0);

      for (int i = 0; i < 60; i++) begin
         sum = $urandom;
         sum = sum >> $urandom_range(0, 31);
         if ($urandom_range(0, 9) == 0) sum = '0;
         if ($urandom_range(0, 3) == 0) sum[7:0] = 8'h80;
         if ($urandom_range(0, 3) == 0) ex = 8'($urandom_range(1, 12));
         else if ($urandom_range(0, 5) == 0) ex = 8'd254;
         else ex = 8'($urandom_range(1, 254));
         do_op(sum, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ex, $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
